// File: rtl/tlb_pkg.sv
// Shared types for the multi-port joint TLB: the stored entry, a page half and field widths.
package tlb_pkg;

  localparam int VPN2_WIDTH = 19;
  localparam int PFN_WIDTH  = 20;
  localparam int ASID_WIDTH = 8;
  localparam int C_WIDTH    = 3;

  typedef struct packed {
    logic [PFN_WIDTH-1:0] pfn;
    logic [C_WIDTH-1:0]   c;
    logic                 d;
    logic                 v;
  } tlb_page_t;

  typedef struct packed {
    logic [VPN2_WIDTH-1:0] vpn2;
    logic [ASID_WIDTH-1:0] asid;
    logic                  g;
    logic                  e;
    tlb_page_t             p0;
    tlb_page_t             p1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match_enc.sv
// Reduces a per-entry match vector to hit, lowest hit index and multi-hit.
module tlb_match_enc #(
  parameter  int TLBNUM = 32,
  localparam int IDX_W  = $clog2(TLBNUM)
) (
  input  logic [TLBNUM-1:0] match_i,
  output logic              found_o,
  output logic              multi_o,
  output logic [IDX_W-1:0]  idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign found_o = |match_i;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_o = |(match_i & (match_i - TLBNUM'(1)));

endmodule

// File: rtl/tlb_mp.sv
// Joint TLB with NSPORT registered search ports, registered read, Wired/Random
// replacement counter and single-cycle ASID / global invalidation.
module tlb_mp
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 32,
  parameter  int NSPORT = 2,
  parameter  int VPN2_W = VPN2_WIDTH,
  parameter  int PFN_W  = PFN_WIDTH,
  parameter  int ASID_W = ASID_WIDTH,
  localparam int IDX_W  = $clog2(TLBNUM)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NSPORT-1:0]        s_req,
  input  logic [NSPORT*VPN2_W-1:0] s_vpn2,
  input  logic [NSPORT-1:0]        s_odd_page,
  input  logic [NSPORT*ASID_W-1:0] s_asid,
  output logic [NSPORT-1:0]        s_rsp_valid,
  output logic [NSPORT-1:0]        s_found,
  output logic [NSPORT-1:0]        s_multi,
  output logic [NSPORT*IDX_W-1:0]  s_index,
  output logic [NSPORT*PFN_W-1:0]  s_pfn,
  output logic [NSPORT*3-1:0]      s_c,
  output logic [NSPORT-1:0]        s_d,
  output logic [NSPORT-1:0]        s_v,
  input  logic                     we,
  input  logic                     w_random,
  input  logic [IDX_W-1:0]         w_index,
  input  logic [VPN2_W-1:0]        w_vpn2,
  input  logic [ASID_W-1:0]        w_asid,
  input  logic                     w_g,
  input  logic [PFN_W-1:0]         w_pfn0,
  input  logic [PFN_W-1:0]         w_pfn1,
  input  logic [2:0]               w_c0,
  input  logic [2:0]               w_c1,
  input  logic                     w_d0,
  input  logic                     w_d1,
  input  logic                     w_v0,
  input  logic                     w_v1,
  input  logic                     r_req,
  input  logic [IDX_W-1:0]         r_index,
  output logic                     r_valid,
  output logic [VPN2_W-1:0]        r_vpn2,
  output logic [ASID_W-1:0]        r_asid,
  output logic                     r_g,
  output logic [PFN_W-1:0]         r_pfn0,
  output logic [PFN_W-1:0]         r_pfn1,
  output logic [2:0]               r_c0,
  output logic [2:0]               r_c1,
  output logic                     r_d0,
  output logic                     r_d1,
  output logic                     r_v0,
  output logic                     r_v1,
  output logic                     r_e,
  input  logic                     wired_we,
  input  logic [IDX_W-1:0]         wired,
  output logic [IDX_W-1:0]         random_index,
  input  logic                     inv_req,
  input  logic [ASID_W-1:0]        inv_asid,
  input  logic                     inv_all
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

  tlb_entry_t       tlb_q [TLBNUM];
  tlb_entry_t       w_entry;
  tlb_entry_t       r_entry_q;
  logic             r_valid_q;
  logic [IDX_W-1:0] random_q, wired_q;
  logic [IDX_W-1:0] w_idx;

  // TLBWR targets the pre-edge Random, even when Wired is written on the same edge.
  assign w_idx = w_random ? random_q : w_index;

  always_comb begin
    w_entry      = '0;
    w_entry.vpn2 = w_vpn2;
    w_entry.asid = w_asid;
    w_entry.g    = w_g;
    w_entry.e    = 1'b1;
    w_entry.p0   = '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0};
    w_entry.p1   = '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1};
  end

  // A write to an entry overrides an invalidation of that same entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && w_idx == IDX_W'(i)) begin
          tlb_q[i] <= w_entry;
        end else if (inv_req && (inv_all || (!tlb_q[i].g && tlb_q[i].asid == inv_asid))) begin
          tlb_q[i].e <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wired_q  <= '0;
      random_q <= RAND_TOP;
    end else if (wired_we) begin
      wired_q  <= wired;
      random_q <= RAND_TOP;
    end else if (random_q == wired_q || wired_q >= RAND_TOP) begin
      random_q <= RAND_TOP;
    end else begin
      random_q <= random_q - IDX_W'(1);
    end
  end

  assign random_index = random_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid_q <= 1'b0;
      r_entry_q <= '0;
    end else begin
      r_valid_q <= r_req;
      if (r_req) r_entry_q <= tlb_q[r_index];
    end
  end

  assign r_valid = r_valid_q;
  assign r_vpn2  = r_entry_q.vpn2;
  assign r_asid  = r_entry_q.asid;
  assign r_g     = r_entry_q.g;
  assign r_e     = r_entry_q.e;
  assign r_pfn0  = r_entry_q.p0.pfn;
  assign r_c0    = r_entry_q.p0.c;
  assign r_d0    = r_entry_q.p0.d;
  assign r_v0    = r_entry_q.p0.v;
  assign r_pfn1  = r_entry_q.p1.pfn;
  assign r_c1    = r_entry_q.p1.c;
  assign r_d1    = r_entry_q.p1.d;
  assign r_v1    = r_entry_q.p1.v;

  for (genvar p = 0; p < NSPORT; p++) begin : g_port
    logic [VPN2_W-1:0] key_vpn2;
    logic [ASID_W-1:0] key_asid;
    logic [TLBNUM-1:0] match;
    logic              found, multi;
    logic [IDX_W-1:0]  idx;
    tlb_page_t         page;
    logic              valid_q, found_q, multi_q;
    logic [IDX_W-1:0]  idx_q;
    tlb_page_t         page_q;

    assign key_vpn2 = s_vpn2[p*VPN2_W +: VPN2_W];
    assign key_asid = s_asid[p*ASID_W +: ASID_W];

    always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
        match[i] = tlb_q[i].e && tlb_q[i].vpn2 == key_vpn2 &&
                   (tlb_q[i].g || tlb_q[i].asid == key_asid);
      end
    end

    tlb_match_enc #(.TLBNUM(TLBNUM)) u_enc (
      .match_i (match),
      .found_o (found),
      .multi_o (multi),
      .idx_o   (idx)
    );

    always_comb begin
      page = '0;
      if (found) page = s_odd_page[p] ? tlb_q[idx].p1 : tlb_q[idx].p0;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        valid_q <= 1'b0;
        found_q <= 1'b0;
        multi_q <= 1'b0;
        idx_q   <= '0;
        page_q  <= '0;
      end else begin
        valid_q <= s_req[p];
        if (s_req[p]) begin
          found_q <= found;
          multi_q <= multi;
          idx_q   <= idx;
          page_q  <= page;
        end
      end
    end

    assign s_rsp_valid[p]             = valid_q;
    assign s_found[p]                 = found_q;
    assign s_multi[p]                 = multi_q;
    assign s_index[p*IDX_W +: IDX_W]  = idx_q;
    assign s_pfn[p*PFN_W +: PFN_W]    = page_q.pfn;
    assign s_c[p*3 +: 3]              = page_q.c;
    assign s_d[p]                     = page_q.d;
    assign s_v[p]                     = page_q.v;
  end

endmodule

// File: tb/tb_tlb_mp.sv
// Directed bench for tlb_mp: search, multi-hit, read, Random/Wired, invalidation, reset.
module tb_tlb_mp;

  logic        clk, resetn;
  logic [1:0]  s_req, s_odd_page;
  logic [37:0] s_vpn2;
  logic [15:0] s_asid;
  logic [1:0]  s_rsp_valid, s_found, s_multi, s_d, s_v;
  logic [9:0]  s_index;
  logic [39:0] s_pfn;
  logic [5:0]  s_c;
  logic        we, w_random, w_g, w_d0, w_d1, w_v0, w_v1;
  logic [4:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        r_req, r_valid, r_g, r_d0, r_d1, r_v0, r_v1, r_e;
  logic [4:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        wired_we, inv_req, inv_all;
  logic [4:0]  wired, random_index;
  logic [7:0]  inv_asid;

  int n_tests = 0;
  int n_fail  = 0;

  tlb_mp dut (
    .clk(clk), .resetn(resetn),
    .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_rsp_valid(s_rsp_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
    .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
    .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
    .w_g(w_g), .w_pfn0(w_pfn0), .w_pfn1(w_pfn1), .w_c0(w_c0), .w_c1(w_c1),
    .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
    .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_vpn2(r_vpn2), .r_asid(r_asid),
    .r_g(r_g), .r_pfn0(r_pfn0), .r_pfn1(r_pfn1), .r_c0(r_c0), .r_c1(r_c1),
    .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1), .r_e(r_e),
    .wired_we(wired_we), .wired(wired), .random_index(random_index),
    .inv_req(inv_req), .inv_asid(inv_asid), .inv_all(inv_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [4:0] idx, input logic [18:0] vpn2,
                           input logic [7:0] asid, input logic g,
                           input logic [19:0] pfn0, input logic [19:0] pfn1);
    w_random = 1'b0; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_pfn1 = pfn1; w_c0 = 3'd2; w_c1 = 3'd5;
    w_d0 = 1'b0; w_d1 = 1'b1; w_v0 = 1'b1; w_v1 = 1'b1;
  endtask

  task automatic write_entry(input logic [4:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] asid, input logic g,
                             input logic [19:0] pfn0, input logic [19:0] pfn1);
    set_entry(idx, vpn2, asid, g, pfn0, pfn1);
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic srch(input int p, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s_req[p] = 1'b1;
    s_odd_page[p] = odd;
    s_vpn2[p*19 +: 19] = vpn2;
    s_asid[p*8 +: 8] = asid;
  endtask

  task automatic go();
    tick();
    s_req = '0;
  endtask

  task automatic rd(input logic [4:0] idx);
    r_req = 1'b1; r_index = idx;
    tick();
    r_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    s_req = '0; s_vpn2 = '0; s_odd_page = '0; s_asid = '0;
    we = 0; w_random = 0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 0;
    w_pfn0 = '0; w_pfn1 = '0; w_c0 = '0; w_c1 = '0; w_d0 = 0; w_d1 = 0; w_v0 = 0; w_v1 = 0;
    r_req = 0; r_index = '0; wired_we = 0; wired = '0; inv_req = 0; inv_asid = '0; inv_all = 0;
    tick(); tick();
    check("rst_rsp_valid", 32'(s_rsp_valid), 32'h0);
    check("rst_r_valid", 32'(r_valid), 32'h0);
    check("rst_random", 32'(random_index), 32'd31);
    #2 resetn = 1'b1;
    tick();

    // Empty table: zero key misses on both ports
    srch(0, 19'h0, 1'b0, 8'h0); srch(1, 19'h0, 1'b0, 8'h0);
    go();
    check("empty_valid", 32'(s_rsp_valid), 32'h3);
    check("empty_found", 32'(s_found), 32'h0);

    write_entry(5'd5, 19'h12345, 8'd3, 1'b0, 20'hAAAAA, 20'hBBBBB);
    srch(0, 19'h12345, 1'b1, 8'd3); srch(1, 19'h12345, 1'b0, 8'd4);
    go();
    check("p0_found", 32'(s_found[0]), 32'h1);
    check("p0_index", 32'(s_index[4:0]), 32'd5);
    check("p0_pfn_odd", 32'(s_pfn[19:0]), 32'hBBBBB);
    check("p0_c_odd", 32'(s_c[2:0]), 32'd5);
    check("p0_d_odd", 32'(s_d[0]), 32'h1);
    check("p0_multi", 32'(s_multi[0]), 32'h0);
    check("p1_asid_miss", 32'(s_found[1]), 32'h0);
    check("p1_miss_pfn", 32'(s_pfn[39:20]), 32'h0);
    tick();
    check("hold_valid", 32'(s_rsp_valid), 32'h0);
    check("hold_found", 32'(s_found[0]), 32'h1);

    write_entry(5'd5, 19'h12345, 8'd3, 1'b1, 20'hAAAAA, 20'hBBBBB);
    srch(1, 19'h12345, 1'b0, 8'd4);
    go();
    check("g_found", 32'(s_found[1]), 32'h1);
    check("g_index", 32'(s_index[9:5]), 32'd5);
    check("g_pfn_even", 32'(s_pfn[39:20]), 32'hAAAAA);
    check("g_d_even", 32'(s_d[1]), 32'h0);

    rd(5'd5);
    check("rd_valid", 32'(r_valid), 32'h1);
    check("rd_vpn2", 32'(r_vpn2), 32'h12345);
    check("rd_g_e", {30'h0, r_g, r_e}, 32'h3);
    check("rd_pfn1", 32'(r_pfn1), 32'hBBBBB);
    tick();
    check("rd_valid_drop", 32'(r_valid), 32'h0);
    check("rd_hold_pfn0", 32'(r_pfn0), 32'hAAAAA);

    write_entry(5'd9, 19'h0ABCD, 8'd7, 1'b0, 20'h00009, 20'h00019);
    write_entry(5'd2, 19'h0ABCD, 8'd7, 1'b0, 20'h00002, 20'h00012);
    srch(0, 19'h0ABCD, 1'b0, 8'd7);
    go();
    check("multi_index", 32'(s_index[4:0]), 32'd2);
    check("multi_flag", 32'(s_multi[0]), 32'h1);
    check("multi_pfn", 32'(s_pfn[19:0]), 32'h00002);

    // Random walk with Wired=28; TLBWR issued while Random is 30
    wired = 5'd28; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    check("rnd_31", 32'(random_index), 32'd31);
    tick();
    check("rnd_30", 32'(random_index), 32'd30);
    set_entry(5'd0, 19'h55555, 8'd1, 1'b0, 20'h55555, 20'h55556);
    w_random = 1'b1; we = 1'b1;
    tick();
    we = 1'b0; w_random = 1'b0;
    check("rnd_29", 32'(random_index), 32'd29);
    tick();
    check("rnd_28", 32'(random_index), 32'd28);
    tick();
    check("rnd_wrap", 32'(random_index), 32'd31);
    tick();
    check("rnd_30b", 32'(random_index), 32'd30);
    rd(5'd30);
    check("tlbwr_e30", 32'(r_vpn2), 32'h55555);
    rd(5'd0);
    check("tlbwr_not_idx0", 32'(r_e), 32'h0);

    wired = 5'd0; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    check("wired_we_31", 32'(random_index), 32'd31);
    tick();
    check("rnd_after_w0", 32'(random_index), 32'd30);
    set_entry(5'd0, 19'h66666, 8'd1, 1'b0, 20'h66666, 20'h66667);
    w_random = 1'b1; we = 1'b1; wired = 5'd28; wired_we = 1'b1;
    tick();
    we = 1'b0; w_random = 1'b0; wired_we = 1'b0;
    check("wr_wired_rnd", 32'(random_index), 32'd31);
    rd(5'd30);
    check("wr_wired_pre", 32'(r_vpn2), 32'h66666);

    wired = 5'd31; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    tick(); tick();
    check("rnd_pinned", 32'(random_index), 32'd31);

    write_entry(5'd10, 19'h01000, 8'd3, 1'b0, 20'h1, 20'h2);
    write_entry(5'd11, 19'h01001, 8'd3, 1'b1, 20'h3, 20'h4);
    write_entry(5'd12, 19'h01002, 8'd4, 1'b0, 20'h5, 20'h6);
    inv_req = 1'b1; inv_asid = 8'd3; inv_all = 1'b0;
    tick();
    inv_req = 1'b0;
    srch(0, 19'h01000, 1'b0, 8'd3); srch(1, 19'h01001, 1'b0, 8'd3);
    go();
    check("inv_asid_g0", 32'(s_found[0]), 32'h0);
    check("inv_asid_g1", 32'(s_found[1]), 32'h1);
    srch(0, 19'h01002, 1'b0, 8'd4);
    go();
    check("inv_other_asid", 32'(s_found[0]), 32'h1);

    inv_req = 1'b1; inv_all = 1'b1;
    tick();
    inv_req = 1'b0; inv_all = 1'b0;
    srch(0, 19'h01001, 1'b0, 8'd3); srch(1, 19'h01002, 1'b0, 8'd4);
    go();
    check("inv_all", 32'(s_found), 32'h0);

    write_entry(5'd15, 19'h03000, 8'd5, 1'b0, 20'h7, 20'h8);
    set_entry(5'd14, 19'h02000, 8'd5, 1'b0, 20'h9, 20'hA);
    we = 1'b1; inv_req = 1'b1; inv_all = 1'b1;
    tick();
    we = 1'b0; inv_req = 1'b0; inv_all = 1'b0;
    srch(0, 19'h02000, 1'b0, 8'd5); srch(1, 19'h03000, 1'b0, 8'd5);
    go();
    check("wr_inv_target", 32'(s_found[0]), 32'h1);
    check("wr_inv_index", 32'(s_index[4:0]), 32'd14);
    check("wr_inv_other", 32'(s_found[1]), 32'h0);

    set_entry(5'd20, 19'h04000, 8'd1, 1'b0, 20'hC, 20'hD);
    we = 1'b1;
    srch(0, 19'h04000, 1'b0, 8'd1);
    go();
    we = 1'b0;
    check("same_cycle_miss", 32'(s_found[0]), 32'h0);
    srch(0, 19'h04000, 1'b0, 8'd1);
    go();
    check("next_cycle_hit", 32'(s_found[0]), 32'h1);
    check("next_cycle_idx", 32'(s_index[4:0]), 32'd20);

    // Asynchronous reset while a search and read are in flight
    srch(0, 19'h04000, 1'b0, 8'd1);
    r_req = 1'b1; r_index = 5'd20;
    tick();
    check("pre_rst_valid", 32'(s_rsp_valid[0]), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(s_rsp_valid), 32'h0);
    check("mid_rst_found", 32'(s_found), 32'h0);
    check("mid_rst_rvalid", 32'(r_valid), 32'h0);
    check("mid_rst_random", 32'(random_index), 32'd31);
    s_req = '0; r_req = 1'b0;
    #2 resetn = 1'b1;
    tick();
    srch(0, 19'h04000, 1'b0, 8'd1);
    go();
    check("post_rst_miss", 32'(s_found[0]), 32'h0);
    rd(5'd20);
    check("post_rst_e", 32'(r_e), 32'h0);
    check("post_rst_vpn2", 32'(r_vpn2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
